vga_scan_gen: RTL and testbench
===============================

// Module: vga_scan_gen
// PURPOSE
//  Raster initiator for the VGA path: generates 640x480@60 scan timing from CLK and
//  presents POS_X/POS_Y/DISPLAY_EN to a combinational pixel source (tile map, game
//  renderer). Samples the source's PIXEL_DATA one pixel later and drives R/G/B,
//  HSYNC and VSYNC, aligned to that pixel.
// PARAMETERS
//  CLK_DIV  4    CLK cycles per pixel (100 MHz CLK -> 25 MHz pixel); legal 1..16
//  H_ACT    640  active pixels/line;  H_FP 16;  H_SW 96;  H_BP 48   (H_TOTAL 800)
//  V_ACT    480  active lines/frame;  V_FP 10;  V_SW 2;   V_BP 33   (V_TOTAL 525)
// PORTS
//  CLK          in   1   system clock; everything is on its rising edge
//  RST_IN       in   1   synchronous reset, active-low
//  PIXEL_DATA   in   8   RRRGGGBB colour from the pixel source for POS_X/POS_Y
//  POS_X        out  10  horizontal counter of the current pixel, 0..H_TOTAL-1
//  POS_Y        out  10  vertical counter of the current pixel, 0..V_TOTAL-1
//  DISPLAY_EN   out  1   1 when POS_X<H_ACT and POS_Y<V_ACT
//  PIX_STB      out  1   1-CLK pulse once per pixel period (pixel clock enable)
//  FRAME_START  out  1   1-CLK pulse together with PIX_STB when POS_X=0, POS_Y=0
//  R / G / B    out  3/3/2  colour to DAC; zero while blanking
//  HSYNC, VSYNC out  1   active-low sync pulses
// BEHAVIOUR
//  Reset (RST_IN=0 at a CLK edge): divider=0, h=v=0, POS_X=POS_Y=0, DISPLAY_EN=0,
//   PIX_STB=0, FRAME_START=0, R=G=B=0, HSYNC=VSYNC=1. Reset takes effect on any
//   edge, including mid-line and mid-frame; no partial frame completes afterwards.
//  Divider: counts 0..CLK_DIV-1; PIX_STB=1 in the cycle in which it equals CLK_DIV-1.
//   First PIX_STB is CLK_DIV cycles after RST_IN is released. CLK_DIV=1 -> PIX_STB
//   is held at 1.
//  Stage 0 (counters, advance on PIX_STB): h wraps H_TOTAL-1 -> 0; v increments
//   only on the h wrap, and v wraps V_TOTAL-1 -> 0.
//  Stage 1 (registered on PIX_STB): POS_X=h, POS_Y=v, DISPLAY_EN=(h<H_ACT && v<V_ACT).
//   Internal hs1 = !(h in [H_ACT+H_FP, H_ACT+H_FP+H_SW)) = low for h 656..751.
//   Internal vs1 = !(v in [V_ACT+V_FP, V_ACT+V_FP+V_SW)) = low for v 490..491.
//   POS_X/POS_Y/DISPLAY_EN hold stable for the full pixel period (CLK_DIV cycles).
//  Pixel source: combinational from POS_X/POS_Y; it has at most CLK_DIV CLK cycles
//   to settle.
//  Stage 2 (registered on PIX_STB): {R,G,B} = DISPLAY_EN ? PIXEL_DATA : 8'h00;
//   HSYNC=hs1; VSYNC=vs1. Colour and sync for one pixel change on the same edge.
//   Latency from POS_X/POS_Y update to the matching colour is one pixel period.
//  FRAME_START: 1 in the cycle in which PIX_STB=1 and the stage-1 registers are about
//   to load h=0, v=0. At most one pulse per frame.
//  Widths: h, v and POS_* are 10 bit unsigned. H_TOTAL and V_TOTAL must be <=1024;
//   the bound is checked at elaboration.
//  PIXEL_DATA is ignored outside the active area, and is sampled only on PIX_STB.
// STRUCTURE
//  Package vga_pkg: H_/V_ timing localparams, derived H_TOTAL/V_TOTAL/sync bounds,
//   and the RRRGGGBB field slices. These are shared with the pixel sources and MAP.
//  Sub-module vga_pix_strobe (divider -> PIX_STB). Counters and both pipeline
//   stages are inline.
// TESTING
//  1 Reset: hold RST_IN=0 10 CLK -> all outputs at their reset values; after
//    release, first PIX_STB at cycle 4 (CLK_DIV=4), POS_X=0, POS_Y=0, DISPLAY_EN=1.
//  2 Line timing: count PIX_STB -> POS_X period 800; HSYNC low exactly 96 pixels,
//    with its falling edge one pixel after POS_X=656; DISPLAY_EN high 640 per line.
//  3 Frame timing: 525 lines/frame; VSYNC low 2 lines starting one pixel after
//    POS_Y=490,POS_X=0; FRAME_START once per 420000 PIX_STB.
//  4 Alignment/blanking: source PIXEL_DATA=POS_X[7:0] -> {R,G,B}==prev POS_X[7:0]
//    in active area; {R,G,B}=0 for POS_X>=640 or POS_Y>=480 even when PIXEL_DATA=8'hFF.
//  5 Mid-frame reset: pulse RST_IN=0 at POS_X=300,POS_Y=200 -> next cycle reset
//    values; the scan restarts at 0,0 and the next FRAME_START comes after 420000 px.
//  6 CLK_DIV=1 build: PIX_STB constant 1; the line still has 800 CLK, and
//    the checks from tests 2 and 4 pass.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing and the RRRGGGBB colour layout.
// The pixel sources use these too, so that everything agrees on one geometry.
package vga_pkg;
  localparam int CNT_W = 10;

  localparam int H_ACT = 640;
  localparam int H_FP  = 16;
  localparam int H_SW  = 96;
  localparam int H_BP  = 48;
  localparam int V_ACT = 480;
  localparam int V_FP  = 10;
  localparam int V_SW  = 2;
  localparam int V_BP  = 33;

  localparam int H_TOTAL  = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOTAL  = V_ACT + V_FP + V_SW + V_BP;
  localparam int H_SW_BEG = H_ACT + H_FP;
  localparam int H_SW_END = H_ACT + H_FP + H_SW;
  localparam int V_SW_BEG = V_ACT + V_FP;
  localparam int V_SW_END = V_ACT + V_FP + V_SW;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan generator <-> pixel source / DAC signals. master = scan generator.
interface vga_scan_gen_if;
  import vga_pkg::*;
  logic [7:0]       PIXEL_DATA;
  logic [CNT_W-1:0] POS_X;
  logic [CNT_W-1:0] POS_Y;
  logic             DISPLAY_EN;
  logic             PIX_STB;
  logic             FRAME_START;
  logic [2:0]       R;
  logic [2:0]       G;
  logic [1:0]       B;
  logic             HSYNC;
  logic             VSYNC;

  modport master (input PIXEL_DATA,
                  output POS_X, POS_Y, DISPLAY_EN, PIX_STB, FRAME_START, R, G, B, HSYNC, VSYNC);
  modport slave  (output PIXEL_DATA,
                  input POS_X, POS_Y, DISPLAY_EN, PIX_STB, FRAME_START, R, G, B, HSYNC, VSYNC);
endinterface

// File: rtl/vga_pix_strobe.sv
// Clock divider producing a one-cycle pixel enable every CLK_DIV clocks.
module vga_pix_strobe #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic stb_o
);
  localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_pix_strobe: CLK_DIV must be 1..16");
  end

  logic [3:0] div_q, div_d;
  logic       stb_q;

  assign div_d = (div_q == LAST) ? 4'd0 : div_q + 4'd1;

  // Strobe is registered from the next divider value so it is 0 in reset,
  // yet equals (div_q == LAST) afterwards; CLK_DIV=1 then holds it at 1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= '0;
      stb_q <= 1'b0;
    end else begin
      div_q <= div_d;
      stb_q <= (div_d == LAST);
    end
  end

  assign stb_o = stb_q;
endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster initiator: h/v counters, position stage for the pixel source,
// and a colour/sync stage aligned one pixel later.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_ACT   = vga_pkg::H_ACT,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SW    = vga_pkg::H_SW,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_ACT   = vga_pkg::V_ACT,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SW    = vga_pkg::V_SW,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic           CLK,
  input  logic           RST_IN,
  vga_scan_gen_if.master vga
);
  localparam int HT = H_ACT + H_FP + H_SW + H_BP;
  localparam int VT = V_ACT + V_FP + V_SW + V_BP;

  if (HT > 1024 || VT > 1024) begin : g_bad_total
    $error("vga_scan_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  localparam logic [CNT_W-1:0] HT_M1 = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] VT_M1 = CNT_W'(VT - 1);
  // Bounds one bit wider: a sync end may sit exactly at 1024.
  localparam logic [CNT_W:0] HA     = (CNT_W+1)'(H_ACT);
  localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_ACT + H_FP);
  localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_ACT + H_FP + H_SW);
  localparam logic [CNT_W:0] VA     = (CNT_W+1)'(V_ACT);
  localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_ACT + V_FP);
  localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_ACT + V_FP + V_SW);

  logic stb;

  vga_pix_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
    .clk_i  (CLK),
    .rst_ni (RST_IN),
    .stb_o  (stb)
  );

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (stb) begin
      if (h_q == HT_M1) begin
        h_d = '0;
        v_d = (v_q == VT_M1) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  logic [CNT_W:0] hx, vx;
  assign hx = {1'b0, h_q};
  assign vx = {1'b0, v_q};

  logic [CNT_W-1:0] posx_q, posy_q;
  logic             de_q, hs1_q, vs1_q;
  rgb332_t          rgb_q;
  logic             hsync_q, vsync_q;

  always_ff @(posedge CLK) begin
    if (!RST_IN) begin
      h_q     <= '0;
      v_q     <= '0;
      posx_q  <= '0;
      posy_q  <= '0;
      de_q    <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (stb) begin
        posx_q  <= h_q;
        posy_q  <= v_q;
        de_q    <= (hx < HA) && (vx < VA);
        hs1_q   <= !((hx >= HS_BEG) && (hx < HS_END));
        vs1_q   <= !((vx >= VS_BEG) && (vx < VS_END));
        // Source output for posx_q/posy_q has had a whole pixel period to settle.
        rgb_q   <= de_q ? rgb332_t'(vga.PIXEL_DATA) : '0;
        hsync_q <= hs1_q;
        vsync_q <= vs1_q;
      end
    end
  end

  assign vga.POS_X       = posx_q;
  assign vga.POS_Y       = posy_q;
  assign vga.DISPLAY_EN  = de_q;
  assign vga.PIX_STB     = stb;
  assign vga.FRAME_START = stb && (h_q == '0) && (v_q == '0);
  assign vga.R           = rgb_q.r;
  assign vga.G           = rgb_q.g;
  assign vga.B           = rgb_q.b;
  assign vga.HSYNC       = hsync_q;
  assign vga.VSYNC       = vsync_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Three scan generators (full timing /4, full timing /1, tiny timing /3) checked
// every cycle against an arithmetic model indexed by clocks since reset release.
module tb_vga_scan_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r4 = 1'b0, r1 = 1'b0, rs = 1'b0;
  int   n_chk = 0, n_pass = 0;

  vga_scan_gen_if if4 ();
  vga_scan_gen_if if1 ();
  vga_scan_gen_if ifs ();

  vga_scan_gen #(.CLK_DIV(4)) u4 (.CLK(clk), .RST_IN(r4), .vga(if4));
  vga_scan_gen #(.CLK_DIV(1)) u1 (.CLK(clk), .RST_IN(r1), .vga(if1));
  vga_scan_gen #(.CLK_DIV(3), .H_ACT(16), .H_FP(2), .H_SW(4), .H_BP(3),
                 .V_ACT(6), .V_FP(2), .V_SW(2), .V_BP(3))
    us (.CLK(clk), .RST_IN(rs), .vga(ifs));

  logic [7:0] salt1, salts;

  // Pixel source: FF outside the active area so that blanking is visible.
  function automatic logic [7:0] src(input logic [9:0] x, input logic [9:0] y,
                                     input logic [7:0] salt, input bit mix,
                                     input int ha, input int va);
    if (int'(x) < ha && int'(y) < va)
      return x[7:0] ^ (mix ? {y[4:0], 3'b000} ^ salt : 8'h00);
    return 8'hFF;
  endfunction

  assign if4.PIXEL_DATA = src(if4.POS_X, if4.POS_Y, 8'h00, 1'b0, 640, 480);
  assign if1.PIXEL_DATA = src(if1.POS_X, if1.POS_Y, salt1, 1'b1, 640, 480);
  assign ifs.PIXEL_DATA = src(ifs.POS_X, ifs.POS_Y, salts, 1'b1, 16, 6);

  // {stb, fs, de, hsync, vsync, pos_x[9:0], pos_y[9:0], rgb[7:0]}
  logic [32:0] o4, o1, os;
  assign o4 = {if4.PIX_STB, if4.FRAME_START, if4.DISPLAY_EN, if4.HSYNC, if4.VSYNC,
               if4.POS_X, if4.POS_Y, if4.R, if4.G, if4.B};
  assign o1 = {if1.PIX_STB, if1.FRAME_START, if1.DISPLAY_EN, if1.HSYNC, if1.VSYNC,
               if1.POS_X, if1.POS_Y, if1.R, if1.G, if1.B};
  assign os = {ifs.PIX_STB, ifs.FRAME_START, ifs.DISPLAY_EN, ifs.HSYNC, ifs.VSYNC,
               ifs.POS_X, ifs.POS_Y, ifs.R, ifs.G, ifs.B};

  // k = clock edges taken with reset released. Pixel n is presented on POS after
  // the (n+1)-th strobed edge; its colour/sync appear one strobed edge later.
  function automatic logic [32:0] model(input int d, input int ha, input int hf,
                                        input int hs, input int hb, input int va,
                                        input int vf, input int vs, input int vb,
                                        input int k, input logic [7:0] salt, input bit mix);
    int ht, vt, p, x, y;
    logic stb, fs, de, hsy, vsy;
    logic [9:0] px, py;
    logic [7:0] rgb;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    stb = (k >= 1) && (k % d == d - 1);
    p   = k / d - ((d == 1 && k > 0) ? 1 : 0);
    fs  = stb && (p % (ht * vt) == 0);
    px = '0; py = '0; de = 1'b0; rgb = '0; hsy = 1'b1; vsy = 1'b1;
    if (p >= 1) begin
      x  = (p - 1) % ht;
      y  = ((p - 1) / ht) % vt;
      px = 10'(x);
      py = 10'(y);
      de = (x < ha) && (y < va);
    end
    if (p >= 2) begin
      x   = (p - 2) % ht;
      y   = ((p - 2) / ht) % vt;
      rgb = (x < ha && y < va) ? src(10'(x), 10'(y), salt, mix, ha, va) : 8'h00;
      hsy = !(x >= ha + hf && x < ha + hf + hs);
      vsy = !(y >= va + vf && y < va + vf + vs);
    end
    return {stb, fs, de, hsy, vsy, px, py, rgb};
  endfunction

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (stb,fs,de,hs,vs,x,y,rgb) t=%0t", tag, got, exp, $time);
  endtask

  initial begin
    int k4, k1, ks, rst4_at;
    bit mid_done;
    logic [32:0] e4, e1, es;
    k4 = 0; k1 = 0; ks = 0; mid_done = 1'b0;
    salt1   = 8'($urandom);
    salts   = 8'($urandom);
    rst4_at = $urandom_range(7000, 9000);
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(posedge clk);
      k4 = r4 ? k4 + 1 : 0;
      k1 = r1 ? k1 + 1 : 0;
      ks = rs ? ks + 1 : 0;
      @(negedge clk);
      e4 = model(4, 640, 16, 96, 48, 480, 10, 2, 33, k4, 8'h00, 1'b0);
      e1 = model(1, 640, 16, 96, 48, 480, 10, 2, 33, k1, salt1, 1'b1);
      es = model(3, 16, 2, 4, 3, 6, 2, 2, 3, ks, salts, 1'b1);
      chk(cyc < 10 ? "rst_div4" : "scan_div4", o4, e4);
      chk(cyc < 10 ? "rst_div1" : "scan_div1", o1, e1);
      chk(cyc < 10 ? "rst_tiny" : "scan_tiny", os, es);
      // Reset decisions for the next edge: 10-cycle initial hold, then pulses.
      r4 = (cyc >= 9) && (cyc != rst4_at);
      r1 = (cyc >= 9) && ($urandom_range(0, 3999) != 0);
      rs = (cyc >= 9);
      if (!mid_done && ks > 1000 && es[32] && es[27:18] == 10'd10 && es[17:8] == 10'd4) begin
        rs = 1'b0;
        mid_done = 1'b1;
      end else if ($urandom_range(0, 1499) == 0) begin
        rs = 1'b0;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
